// File: rtl/calc_hist.sv
// Accumulator calculator with DEPTH-entry undo history, WIDTH-cycle shift-add multiplier and status flags.
// Optional build macro CALC_SAT_EN: ADD/SUB saturate to signed limits, MUL saturates to all-ones.
module calc_hist #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         btnu,
  input  logic                         btnd,
  input  logic                         btnl,
  input  logic                         btnc,
  input  logic                         btnr,
  input  logic [WIDTH-1:0]             sw,
  output logic [WIDTH-1:0]             led,
  output logic                         busy,
  output logic                         ovf,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   hcnt
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int HW    = $clog2(DEPTH+1);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                 state_q, state_d;
  logic                   btnd_q;
  logic [WIDTH-1:0]       acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic                   err_q, err_d;
  logic [HW-1:0]          hcnt_q, hcnt_d;
  logic [WIDTH-1:0]       hist_q [DEPTH];
  logic [WIDTH-1:0]       hist_d [DEPTH];
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   exec;
  logic [2:0]             op;
  logic                   do_push;

`ifdef CALC_SAT_EN
  function automatic logic [WIDTH-1:0] sat_s(input logic [WIDTH-1:0] res, input logic ov,
                                             input logic neg);
    if (!ov) return res;
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  function automatic logic [WIDTH-1:0] sat_u(input logic [WIDTH-1:0] res, input logic ov);
    return ov ? {WIDTH{1'b1}} : res;
  endfunction
`endif

  assign exec = btnd & ~btnd_q;
  assign op   = {btnl, btnc, btnr};

  logic signed [WIDTH-1:0] a_s, b_s, sum_s, diff_s;
  logic [2*WIDTH-1:0]      shl_full;
  logic                    add_ov, sub_ov;
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_ovf;

  assign a_s      = acc_q;
  assign b_s      = sw;
  assign sum_s    = a_s + b_s;
  assign diff_s   = a_s - b_s;
  assign shl_full = {{WIDTH{1'b0}}, acc_q} << sw[SHW-1:0];
  // Signed overflow: result sign disagrees with what the operand signs allow.
  assign add_ov   = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1]  != a_s[WIDTH-1]);
  assign sub_ov   = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (diff_s[WIDTH-1] != a_s[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      3'b000: begin
`ifdef CALC_SAT_EN
        alu_res = sat_s(sum_s, add_ov, a_s[WIDTH-1]);
`else
        alu_res = sum_s;
`endif
        alu_ovf = add_ov;
      end
      3'b001: begin
`ifdef CALC_SAT_EN
        alu_res = sat_s(diff_s, sub_ov, a_s[WIDTH-1]);
`else
        alu_res = diff_s;
`endif
        alu_ovf = sub_ov;
      end
      3'b010: alu_res = acc_q & sw;
      3'b011: alu_res = acc_q | sw;
      3'b100: alu_res = acc_q ^ sw;
      3'b101: begin
        alu_res = shl_full[WIDTH-1:0];
        alu_ovf = |shl_full[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  logic [2*WIDTH-1:0] mul_step;
  logic               mul_ov;
  logic [WIDTH-1:0]   mul_res;

  assign mul_step = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_ov   = |mul_step[2*WIDTH-1:WIDTH];
`ifdef CALC_SAT_EN
  assign mul_res  = sat_u(mul_step[WIDTH-1:0], mul_ov);
`else
  assign mul_res  = mul_step[WIDTH-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    err_d    = 1'b0;
    hcnt_d   = hcnt_q;
    hist_d   = hist_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    do_push  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (exec) begin
          if (op == 3'b110) begin
            state_d  = S_MUL;
            mcand_d  = {{WIDTH{1'b0}}, acc_q};
            mplier_d = sw;
            prod_d   = '0;
            cnt_d    = '0;
          end else if (op == 3'b111) begin
            if (hcnt_q != '0) begin
              for (int i = 0; i < DEPTH; i++)
                if (HW'(i + 1) == hcnt_q) acc_d = hist_q[i];
              hcnt_d = hcnt_q - HW'(1);
              ovf_d  = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            acc_d   = alu_res;
            ovf_d   = alu_ovf;
            do_push = 1'b1;
          end
        end
      end
      S_MUL: begin
        prod_d   = mul_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = S_IDLE;
          acc_d   = mul_res;
          ovf_d   = mul_ov;
          do_push = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Push the pre-op accumulator; when full, the oldest entry falls off index 0.
    if (do_push) begin
      if (hcnt_q == HW'(DEPTH)) begin
        for (int i = 0; i < DEPTH-1; i++) hist_d[i] = hist_q[i+1];
        hist_d[DEPTH-1] = acc_q;
      end else begin
        for (int i = 0; i < DEPTH; i++)
          if (HW'(i) == hcnt_q) hist_d[i] = acc_q;
        hcnt_d = hcnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    btnd_q <= btnd;
    if (btnu) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // History contents and multiplier datapath are qualified by hcnt/state, so they need no reset.
  always_ff @(posedge clk) begin
    hist_q   <= hist_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    prod_q   <= prod_d;
    cnt_q    <= cnt_d;
  end

  assign led  = acc_q;
  assign busy = (state_q == S_MUL);
  assign ovf  = ovf_q;
  assign err  = err_q;
  assign hcnt = hcnt_q;

endmodule

// File: tb/tb_calc_hist.sv
// Directed self-checking bench for calc_hist (WIDTH=16, DEPTH=4); expectations follow CALC_SAT_EN.
module tb_calc_hist;

  logic        clk = 1'b0;
  logic        btnu, btnd, btnl, btnc, btnr;
  logic [15:0] sw;
  logic [15:0] led;
  logic        busy, ovf, err;
  logic [2:0]  hcnt;

  int ncheck = 0;
  int nfail  = 0;

  calc_hist #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .btnu(btnu), .btnd(btnd), .btnl(btnl), .btnc(btnc), .btnr(btnr),
    .sw(sw), .led(led), .busy(busy), .ovf(ovf), .err(err), .hcnt(hcnt)
  );

  always #5 clk = ~clk;

`ifdef CALC_SAT_EN
  localparam logic [15:0] ADD_OV_EXP = 16'h7FFF;
  localparam logic [15:0] SUB_OV_EXP = 16'h7FFF;
  localparam logic [15:0] MUL_OV_EXP = 16'hFFFF;
`else
  localparam logic [15:0] ADD_OV_EXP = 16'h8000;
  localparam logic [15:0] SUB_OV_EXP = 16'h8000;
  localparam logic [15:0] MUL_OV_EXP = 16'h0000;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncheck++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    btnu = 1'b1;
    tick();
    btnu = 1'b0;
  endtask

  // Low cycle first so the rising edge is seen; returns just after the exec edge.
  task automatic do_exec(input logic [2:0] op, input logic [15:0] b);
    {btnl, btnc, btnr} = op;
    sw   = b;
    btnd = 1'b0;
    tick();
    btnd = 1'b1;
    tick();
    btnd = 1'b0;
  endtask

  task automatic do_mul(input logic [15:0] b, input logic [15:0] pre, input logic [15:0] exp,
                        input logic exp_ovf, input bit poke);
    do_exec(3'b110, b);
    check("mul_busy_start", busy, 1);
    check("mul_led_hold", led, pre);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("mul_busy_run", busy, 1);
      check("mul_led_run", led, pre);
      if (poke && i == 5) btnd = 1'b1;
      if (poke && i == 6) btnd = 1'b0;
    end
    tick();
    check("mul_busy_done", busy, 0);
    check("mul_led_done", led, exp);
    check("mul_ovf_done", ovf, exp_ovf);
    tick();
    check("mul_idle_after", busy, 0);
    check("mul_led_after", led, exp);
  endtask

  initial begin
    btnu = 1'b1; btnd = 1'b1; btnl = 1'b0; btnc = 1'b0; btnr = 1'b0; sw = 16'h5555;
    tick();
    tick();
    btnu = 1'b0;
    tick();
    check("rst_led", led, 16'h0000);
    check("rst_hcnt", hcnt, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err", err, 0);
    tick();
    check("held_btnd_led", led, 16'h0000);
    check("held_btnd_hcnt", hcnt, 0);

    do_exec(3'b000, 16'h1234);
    check("add_led", led, 16'h1234);
    check("add_hcnt", hcnt, 1);
    do_exec(3'b001, 16'h0FF0);
    check("sub_led", led, 16'h0244);
    check("sub_hcnt", hcnt, 2);
    check("sub_ovf", ovf, 0);

    do_exec(3'b010, 16'h00FF);
    check("and_led", led, 16'h0044);
    do_exec(3'b011, 16'h1200);
    check("or_led", led, 16'h1244);
    check("or_hcnt", hcnt, 4);
    do_exec(3'b100, 16'hFFFF);
    check("xor_led", led, 16'hEDBB);
    check("xor_hcnt_full", hcnt, 4);
    do_exec(3'b101, 16'h0004);
    check("shl_led", led, 16'hDBB0);
    check("shl_ovf", ovf, 1);
    do_exec(3'b111, 16'h0000);
    check("undo_full_led", led, 16'hEDBB);
    check("undo_full_hcnt", hcnt, 3);
    check("undo_full_ovf", ovf, 0);
    do_exec(3'b111, 16'h0000);
    check("undo_full2_led", led, 16'h1244);

    do_reset();
    do_exec(3'b000, 16'h7FFF);
    check("add_max_led", led, 16'h7FFF);
    check("add_max_ovf", ovf, 0);
    do_exec(3'b000, 16'h0001);
    check("add_ov_led", led, ADD_OV_EXP);
    check("add_ov_ovf", ovf, 1);
    do_exec(3'b010, 16'hFFFF);
    check("and_clr_ovf", ovf, 0);
    do_reset();
    do_exec(3'b001, 16'h8000);
    check("sub_ov_led", led, SUB_OV_EXP);
    check("sub_ov_ovf", ovf, 1);

    do_reset();
    do_exec(3'b000, 16'h0100);
    do_mul(16'h0100, 16'h0100, MUL_OV_EXP, 1'b1, 1'b1);
    check("mul_ov_hcnt", hcnt, 2);
    do_reset();
    do_exec(3'b000, 16'h0012);
    do_mul(16'h0034, 16'h0012, 16'h03A8, 1'b0, 1'b0);
    check("mul_hcnt", hcnt, 2);

    do_reset();
    do_exec(3'b000, 16'h0001);
    do_exec(3'b000, 16'h0002);
    do_exec(3'b000, 16'h0003);
    do_exec(3'b000, 16'h0004);
    do_exec(3'b000, 16'h0005);
    check("hist_sum_led", led, 16'h000F);
    check("hist_full_hcnt", hcnt, 4);
    do_exec(3'b111, 16'h0000);
    check("undo1_led", led, 16'h000A);
    check("undo1_hcnt", hcnt, 3);
    do_exec(3'b111, 16'h0000);
    check("undo2_led", led, 16'h0006);
    do_exec(3'b111, 16'h0000);
    check("undo3_led", led, 16'h0003);
    do_exec(3'b111, 16'h0000);
    check("undo4_led", led, 16'h0001);
    check("undo4_hcnt", hcnt, 0);
    check("undo4_err", err, 0);
    do_exec(3'b111, 16'h0000);
    check("undo_empty_led", led, 16'h0001);
    check("undo_empty_err", err, 1);
    check("undo_empty_hcnt", hcnt, 0);
    tick();
    check("err_pulse_end", err, 0);

    do_reset();
    do_exec(3'b000, 16'h0100);
    do_exec(3'b110, 16'h0100);
    check("abort_busy_pre", busy, 1);
    for (int i = 0; i < 5; i++) tick();
    btnu = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_led", led, 16'h0000);
    check("abort_hcnt", hcnt, 0);
    check("abort_ovf", ovf, 0);
    check("abort_err", err, 0);
    btnu = 1'b0;
    tick();
    tick();
    check("abort_idle_busy", busy, 0);
    check("abort_idle_led", led, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
    $finish;
  end

endmodule
